serial_prog_loader: RTL and testbench
=====================================

Name: serial_prog_loader

Overview:
- Receives a program image over a single-wire 8N1 serial line.
- Writes each received byte into the CPU's 32-word instruction memory at incrementing addresses.
- Holds the CPU in reset until the programmed word count has been written, then releases it.
- Sits directly upstream of the cpu block and replaces file-based memory preload on silicon.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; must be an even value ≥ 4.
- DATA_W, 8, instruction width: 3-bit opcode plus 5-bit operand.
- ADDR_W, 5, memory address width, giving 32 words.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RXD  in  1  serial data; idle high, LSB first, asynchronous to CLK.
- START  in  1  one-cycle pulse that begins a load; ignored while BUSY=1.
- WORD_CNT  in  ADDR_W+1  number of words to load; sampled on START.
- MEM_WE  out  1  one-cycle memory write strobe.
- MEM_ADDR  out  ADDR_W  write address.
- MEM_WDATA  out  DATA_W  write data.
- CPU_RST  out  1  active-high reset to the cpu.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse when the load completes.
- FRAME_ERR  out  1  sticky; cleared by the next accepted START.
- PARITY_ERR  out  1  sticky; tied 0 when parity is compiled out.

Behaviour:
- Reset values: MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_RST=1, BUSY=0, DONE=0, FRAME_ERR=0, PARITY_ERR=0, FSM=IDLE.
- RXD passes through a 2-flop synchronizer, which reset-initialises to 1. All RXD timing below refers to the synchronized signal.
- WORD_CNT=0 means no words: DONE pulses 1 cycle after START, with no writes. WORD_CNT>32 is clamped to 32.
- FSM states: IDLE, WAIT_START, START_BIT, DATA, PARITY, STOP, WRITE, RELEASE.
- IDLE: START with WORD_CNT≠0 → WAIT_START. On that transition: BUSY=1, CPU_RST=1, MEM_ADDR=0, remaining=WORD_CNT, error flags cleared.
- WAIT_START: a falling edge on RXD → START_BIT, and the bit counter is loaded.
- START_BIT: at count CLKS_PER_BIT/2-1, sample RXD.
  - RXD=1: glitch → WAIT_START, no side effects.
  - RXD=0: → DATA.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first. Then → PARITY if the parity feature is compiled in, else → STOP.
- STOP: sample at the bit centre.
  - RXD=0: FRAME_ERR=1, byte discarded, address unchanged → WAIT_START.
  - RXD=1: → WRITE.
- WRITE: one cycle; MEM_WE=1 with the current MEM_ADDR and MEM_WDATA.
  - Next cycle: MEM_ADDR+1 and remaining-1.
  - If remaining was 1: → RELEASE; else → WAIT_START.
- Write latency: MEM_WE is asserted exactly 1 cycle after the stop-bit centre sample.
- MEM_ADDR wrap: the increment after address 31 wraps to 0. This only happens on the final word, because WORD_CNT is clamped to 32, so no overwrite can occur.
- RELEASE: one cycle. CPU_RST=0 registered, DONE=1 pulse, BUSY=0 → IDLE.
  - CPU_RST stays 0 until the next accepted START or RST_N.
- A START pulse in any state other than IDLE is ignored.
- If START and a falling RXD edge arrive in the same IDLE cycle, START takes priority; the edge is not captured.
- RST_N asserted mid-frame: immediate return to the reset values; any partial byte is lost and CPU_RST=1.

Optional Feature:
- Macro: SERIAL_PROG_LOADER_PARITY_EN.
- Defined:
  - An even-parity bit is received between the data bits and the stop bit.
  - On mismatch, PARITY_ERR=1 and the byte is discarded; the stop bit is still checked, then → WAIT_START with the address unchanged.
- Undefined:
  - The PARITY state is unreachable and the frame is 10 bits.
  - PARITY_ERR is driven constant 0.

Decomposition:
- Package serial_loader_pkg holds:
  - the FSM state enum;
  - the localparams FRAME_DATA_BITS=8 and MAX_WORDS=32;
  - a function that clamps WORD_CNT.
- Sub-module rx_sync_edge: 2-flop synchronizer plus falling-edge detect, with its own CLK and RST_N.
- The counters, FSM and datapath stay in the top module.

Test Plan (CLKS_PER_BIT=16):
- Basic load: WORD_CNT=3, then send bytes 0xA3, 0x17, 0xFF. Required: MEM_WE pulses at addresses 0, 1, 2 with those data; DONE pulses once; CPU_RST falls the same cycle as DONE.
- Glitch rejection: RXD low for 4 cycles in WAIT_START. Required: no write, BUSY stays 1; the next valid 0x5C is written to address 0.
- Framing error: byte 0x3E sent with stop bit 0. Required: FRAME_ERR=1, no MEM_WE; the next good byte 0x41 goes to address 0.
- Full memory: WORD_CNT=40 (clamped to 32), 32 bytes sent. Required: the last write is at address 31, DONE pulses, no 33rd write.
- Reset mid-frame: RST_N low during bit 4 of the second byte. Required: CPU_RST=1 and MEM_ADDR=0 immediately; the new START reloads from address 0.
- Parity (macro defined): 0x07 sent with parity bit 0. Required: PARITY_ERR=1, no write. With the macro undefined, PARITY_ERR stays 0 throughout.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared FSM state type, frame constants and word-count clamp for serial_prog_loader
package serial_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START_BIT,
        DATA,
        PARITY,
        STOP,
        WRITE,
        RELEASE
    } state_e;

    localparam int FRAME_DATA_BITS = 8;
    localparam int MAX_WORDS       = 32;
    localparam int WCNT_W          = 6;

    // Requests beyond the memory depth load the whole memory once, never wrapping onto earlier words.
    function automatic logic [WCNT_W-1:0] clamp_word_cnt(input logic [WCNT_W-1:0] n);
        return (n > WCNT_W'(MAX_WORDS)) ? WCNT_W'(MAX_WORDS) : n;
    endfunction

endpackage

// File: rtl/serial_prog_loader_if.sv
// serial_prog_loader_if: command, memory-write and status bundle of serial_prog_loader
// Signals: START/WORD_CNT (load command), MEM_WE/MEM_ADDR/MEM_WDATA (instruction memory write port),
//          CPU_RST, BUSY, DONE, FRAME_ERR, PARITY_ERR (status).
// Modports: master = controller side driving the command, slave = the loader.
interface serial_prog_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              START;
    logic [ADDR_W:0]   WORD_CNT;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              CPU_RST;
    logic              BUSY;
    logic              DONE;
    logic              FRAME_ERR;
    logic              PARITY_ERR;

    modport master (
        output START, WORD_CNT,
        input  MEM_WE, MEM_ADDR, MEM_WDATA, CPU_RST, BUSY, DONE, FRAME_ERR, PARITY_ERR
    );

    modport slave (
        input  START, WORD_CNT,
        output MEM_WE, MEM_ADDR, MEM_WDATA, CPU_RST, BUSY, DONE, FRAME_ERR, PARITY_ERR
    );
endinterface

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: 2-flop synchronizer for the serial line plus falling-edge detect on the synced value
// Ports: CLK, RST_N (async active-low), rxd_i (async serial in),
//        rxd_o (synchronized line), fall_o (one-cycle pulse on a synced 1->0 transition).
module rx_sync_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic rxd_i,
    output logic rxd_o,
    output logic fall_o
);
    // [1:0] synchronizer stages, [2] previous synced value; all reset to the idle-high line level.
    logic [2:0] sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sync_q <= '1;
        else        sync_q <= {sync_q[1:0], rxd_i};
    end

    assign rxd_o  = sync_q[1];
    assign fall_o = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/serial_prog_loader.sv
// serial_prog_loader: receives an 8N1 program image and writes it into the CPU instruction memory
// Optional even-parity bit between data and stop bits: define SERIAL_PROG_LOADER_PARITY_EN.
// Ports: CLK, RST_N (async active-low), RXD (async serial line, idle high, LSB first);
//        bus (slave modport): START/WORD_CNT command in, MEM_WE/MEM_ADDR/MEM_WDATA write port,
//        CPU_RST, BUSY, DONE, FRAME_ERR, PARITY_ERR status out.
module serial_prog_loader
    import serial_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5
) (
    input logic CLK,
    input logic RST_N,
    input logic RXD,
    serial_prog_loader_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(FRAME_DATA_BITS);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIT_W-1:0]    bit_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WCNT_W-1:0]   rem_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                frame_err_q;
    logic                par_ok;
    logic                rxd_s;
    logic                rxd_fall;
    logic                half_bit;
    logic                full_bit;
    logic [WCNT_W-1:0]   n_words;

    rx_sync_edge u_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .rxd_i  (RXD),
        .rxd_o  (rxd_s),
        .fall_o (rxd_fall)
    );

    assign n_words  = clamp_word_cnt(WCNT_W'(bus.WORD_CNT));
    // Timer restarts at 0 on entry to each bit phase: the start bit is checked half a bit in,
    // every later bit one full bit after the previous sample, i.e. at its centre.
    assign half_bit = cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1);
    assign full_bit = cnt_q == CNT_W'(CLKS_PER_BIT - 1);

`ifdef SERIAL_PROG_LOADER_PARITY_EN
    logic parity_err_q;
    logic par_bad_q;

    assign par_ok         = ~par_bad_q;
    assign bus.PARITY_ERR = parity_err_q;
`else
    assign par_ok         = 1'b1;
    assign bus.PARITY_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            wdata_q      <= '0;
            rem_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_PROG_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
            case (state_q)
                IDLE: if (bus.START) begin
                    // A zero-word load completes on the spot: no frames, DONE next cycle.
                    addr_q       <= '0;
                    rem_q        <= n_words;
                    frame_err_q  <= 1'b0;
`ifdef SERIAL_PROG_LOADER_PARITY_EN
                    parity_err_q <= 1'b0;
`endif
                    busy_q       <= |n_words;
                    cpu_rst_q    <= |n_words;
                    done_q       <= ~|n_words;
                    state_q      <= (|n_words) ? WAIT_START : IDLE;
                end
                WAIT_START: if (rxd_fall) begin
                    cnt_q   <= '0;
                    state_q <= START_BIT;
                end
                START_BIT: if (half_bit) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= rxd_s ? WAIT_START : DATA;
                end
                DATA: if (full_bit) begin
                    cnt_q   <= '0;
                    shift_q <= {rxd_s, shift_q[DATA_W-1:1]};
                    bit_q   <= bit_q + 1'b1;
`ifdef SERIAL_PROG_LOADER_PARITY_EN
                    if (bit_q == BIT_W'(FRAME_DATA_BITS - 1)) state_q <= PARITY;
`else
                    if (bit_q == BIT_W'(FRAME_DATA_BITS - 1)) state_q <= STOP;
`endif
                end
`ifdef SERIAL_PROG_LOADER_PARITY_EN
                PARITY: if (full_bit) begin
                    cnt_q     <= '0;
                    par_bad_q <= rxd_s ^ (^shift_q);
                    if (rxd_s ^ (^shift_q)) parity_err_q <= 1'b1;
                    state_q   <= STOP;
                end
`endif
                STOP: if (full_bit) begin
                    cnt_q <= '0;
                    if (!rxd_s) frame_err_q <= 1'b1;
                    if (rxd_s && par_ok) begin
                        we_q    <= 1'b1;
                        wdata_q <= shift_q;
                        state_q <= WRITE;
                    end else begin
                        state_q <= WAIT_START;
                    end
                end
                WRITE: begin
                    addr_q  <= addr_q + 1'b1;
                    rem_q   <= rem_q - 1'b1;
                    state_q <= (rem_q == WCNT_W'(1)) ? RELEASE : WAIT_START;
                end
                RELEASE: begin
                    cpu_rst_q <= 1'b0;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MEM_WE    = we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.CPU_RST   = cpu_rst_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.FRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_serial_prog_loader.sv
// tb_serial_prog_loader: directed, table-driven self-checking bench for serial_prog_loader
module tb_serial_prog_loader;
    localparam int CPB = 16;

    logic CLK = 1'b0;
    logic RST_N;
    logic RXD;

    serial_prog_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    serial_prog_loader #(.CLKS_PER_BIT(CPB), .DATA_W(8), .ADDR_W(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .RXD   (RXD),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic prev_cpu_rst = 1'b1;
    logic [1:0] rst_at_done = 2'b00;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (bus.MEM_WE) begin
                wr_cnt++;
                last_addr = bus.MEM_ADDR;
                last_data = bus.MEM_WDATA;
            end
            if (bus.DONE) begin
                done_cnt++;
                rst_at_done = {prev_cpu_rst, bus.CPU_RST};
            end
        end
        prev_cpu_rst = bus.CPU_RST;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        #1 RXD = b;
        repeat (CPB) @(posedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_PROG_LOADER_PARITY_EN
        drive_bit(par_b);
`endif
        drive_bit(stop_b);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic pulse_start(input logic [5:0] wc);
        @(posedge CLK);
        #1 bus.START = 1'b1;
        bus.WORD_CNT = wc;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        repeat (3) @(posedge CLK);
    endtask

    typedef struct {
        logic       start;
        logic [5:0] wc;
        logic [7:0] data;
        logic       stop;
        logic       exp_wr;
        logic [4:0] exp_addr;
        logic       exp_ferr;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr0, d0;
        vecs[0] = '{1'b1, 6'd3, 8'hA3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 6'd1, 8'h17, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 6'd0, 8'hFF, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd2, 8'h3E, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 6'd0, 8'h41, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 6'd0, 8'hC2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0};

        RST_N = 1'b0;
        RXD = 1'b1;
        bus.START = 1'b0;
        bus.WORD_CNT = '0;
        #12;
        check("rst_mem_we", bus.MEM_WE, 1'b0);
        check("rst_mem_addr", bus.MEM_ADDR, 5'd0);
        check("rst_mem_wdata", bus.MEM_WDATA, 8'd0);
        check("rst_cpu_rst", bus.CPU_RST, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_errs", {bus.FRAME_ERR, bus.PARITY_ERR}, 2'b00);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].start) pulse_start(vecs[v].wc);
            wr0 = wr_cnt;
            d0 = done_cnt;
            send_byte(vecs[v].data, vecs[v].stop, ^vecs[v].data);
            check($sformatf("v%0d_wr", v), wr_cnt - wr0, {31'd0, vecs[v].exp_wr});
            if (vecs[v].exp_wr) begin
                check($sformatf("v%0d_addr", v), last_addr, vecs[v].exp_addr);
                check($sformatf("v%0d_data", v), last_data, vecs[v].data);
            end
            check($sformatf("v%0d_ferr", v), bus.FRAME_ERR, vecs[v].exp_ferr);
            check($sformatf("v%0d_busy", v), bus.BUSY, vecs[v].exp_busy);
            check($sformatf("v%0d_cpu_rst", v), bus.CPU_RST, vecs[v].exp_busy);
            check($sformatf("v%0d_done", v), done_cnt - d0, {31'd0, ~vecs[v].exp_busy});
            if (!vecs[v].exp_busy) check($sformatf("v%0d_rst_at_done", v), rst_at_done, 2'b10);
        end

        // zero-word load: DONE the cycle after START, nothing written
        wr0 = wr_cnt;
        @(posedge CLK);
        #1 bus.START = 1'b1;
        bus.WORD_CNT = 6'd0;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        check("zero_done", bus.DONE, 1'b1);
        check("zero_busy", bus.BUSY, 1'b0);
        @(posedge CLK);
        #1 check("zero_done_pulse", bus.DONE, 1'b0);
        check("zero_no_wr", wr_cnt - wr0, 0);

        // glitch in WAIT_START is rejected
        pulse_start(6'd1);
        wr0 = wr_cnt;
        #1 RXD = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RXD = 1'b1;
        repeat (40) @(posedge CLK);
        check("glitch_no_wr", wr_cnt - wr0, 0);
        check("glitch_busy", bus.BUSY, 1'b1);
        send_byte(8'h5C, 1'b1, ^8'h5C);
        check("glitch_wr", wr_cnt - wr0, 1);
        check("glitch_addr", last_addr, 5'd0);
        check("glitch_data", last_data, 8'h5C);
        check("glitch_done", bus.BUSY, 1'b0);

        // full memory with clamped count
        pulse_start(6'd40);
        wr0 = wr_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 32; i++) send_byte(8'(i * 5 + 3), 1'b1, ^(8'(i * 5 + 3)));
        check("full_wr_cnt", wr_cnt - wr0, 32);
        check("full_last_addr", last_addr, 5'd31);
        check("full_last_data", last_data, 8'h9E);
        check("full_done", done_cnt - d0, 1);
        check("full_rst_at_done", rst_at_done, 2'b10);
        check("full_addr_wrap", bus.MEM_ADDR, 5'd0);
        send_byte(8'h55, 1'b1, ^8'h55);
        check("full_no_33rd", wr_cnt - wr0, 32);

        // reset during bit 4 of the second byte
        pulse_start(6'd3);
        send_byte(8'h11, 1'b1, ^8'h11);
        check("mid_addr_pre", bus.MEM_ADDR, 5'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        #1 RXD = 1'b1;
        repeat (8) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("mid_cpu_rst", bus.CPU_RST, 1'b1);
        check("mid_addr", bus.MEM_ADDR, 5'd0);
        check("mid_busy", bus.BUSY, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        pulse_start(6'd1);
        wr0 = wr_cnt;
        send_byte(8'h66, 1'b1, ^8'h66);
        check("mid_reload_wr", wr_cnt - wr0, 1);
        check("mid_reload_addr", last_addr, 5'd0);
        check("mid_reload_data", last_data, 8'h66);
        check("mid_reload_cpu", bus.CPU_RST, 1'b0);

`ifdef SERIAL_PROG_LOADER_PARITY_EN
        pulse_start(6'd1);
        wr0 = wr_cnt;
        send_byte(8'h07, 1'b1, 1'b0);
        check("par_err", bus.PARITY_ERR, 1'b1);
        check("par_no_wr", wr_cnt - wr0, 0);
        check("par_busy", bus.BUSY, 1'b1);
        send_byte(8'h07, 1'b1, 1'b1);
        check("par_good_wr", wr_cnt - wr0, 1);
        check("par_good_addr", last_addr, 5'd0);
        check("par_good_data", last_data, 8'h07);
`else
        check("par_tied0", bus.PARITY_ERR, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
